miriscv_mem_arbiter: RTL and testbench

//  Shares one external memory port between instruction fetch and load/store unit (LSU).

---
 rtl/miriscv_pkg.sv | 19 +
 rtl/miriscv_arb_src_fifo.sv | 72 +++++++
 rtl/miriscv_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_miriscv_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_pkg.sv
// Shared types for the miriscv memory arbiter: XLEN and the requester ID.
`default_nettype none

package miriscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } arb_src_e;

  function automatic arb_src_e other_src(input arb_src_e s);
    return (s == SRC_DATA) ? SRC_INSTR : SRC_DATA;
  endfunction

endpackage

`default_nettype wire

// File: rtl/miriscv_arb_src_fifo.sv
// miriscv_arb_src_fifo: DEPTH-entry FIFO of requester IDs, one per in-flight transaction.
`default_nettype none

module miriscv_arb_src_fifo
  import miriscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     arstn_i,
  input  logic     push,
  input  arb_src_e push_src,
  input  logic     pop,
  output arb_src_e head,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  arb_src_e store_q [DEPTH];
  ptr_t     wr_ptr_q;
  ptr_t     rd_ptr_q;
  cnt_t     count_q;
  logic     do_push;
  logic     do_pop;

  // Explicit wrap so non-power-of-two depths would still behave.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_LAST) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign head    = store_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= SRC_INSTR;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        store_q[wr_ptr_q] <= push_src;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/miriscv_mem_arbiter.sv
// miriscv_mem_arbiter: shares one memory port between fetch and LSU, routes in-order responses back.
// Optional MIRISCV_ARB_RR_EN selects round-robin instead of fixed data-over-instr priority.
`default_nettype none

module miriscv_mem_arbiter
  import miriscv_pkg::*;
#(
  parameter int MAX_OUTST = 2
) (
  input  logic            clk_i,
  input  logic            arstn_i,

  input  logic            instr_req_i,
  input  logic [XLEN-1:0] instr_addr_i,
  output logic            instr_gnt_o,
  output logic            instr_rvalid_o,
  output logic [XLEN-1:0] instr_rdata_o,

  input  logic            data_req_i,
  input  logic            data_we_i,
  input  logic [3:0]      data_be_i,
  input  logic [XLEN-1:0] data_addr_i,
  input  logic [XLEN-1:0] data_wdata_i,
  output logic            data_gnt_o,
  output logic            data_rvalid_o,
  output logic [XLEN-1:0] data_rdata_o,

  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,

  output logic            arb_err_o
);

  arb_src_e sel;
  arb_src_e lock_src_q;
  logic     lock_q;
  logic     lock_hold;
  logic     mem_grant;
  logic     rsp_ok;
  arb_src_e fifo_head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     err_q;

`ifdef MIRISCV_ARB_RR_EN
  arb_src_e last_src_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      last_src_q <= SRC_INSTR;
    end else if (mem_grant) begin
      last_src_q <= sel;
    end
  end
`endif

  // A request presented but not yet accepted pins its source until granted or withdrawn.
  assign lock_hold = lock_q & ((lock_src_q == SRC_DATA) ? data_req_i : instr_req_i);

  always_comb begin
    sel = SRC_INSTR;
    if (lock_hold) begin
      sel = lock_src_q;
    end else if (instr_req_i && data_req_i) begin
`ifdef MIRISCV_ARB_RR_EN
      sel = other_src(last_src_q);
`else
      sel = SRC_DATA;
`endif
    end else if (data_req_i) begin
      sel = SRC_DATA;
    end
  end

  assign mem_req_o = (instr_req_i | data_req_i) & ~fifo_full;
  assign mem_grant = mem_req_o & mem_gnt_i;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (sel == SRC_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  assign instr_gnt_o = mem_grant & (sel == SRC_INSTR);
  assign data_gnt_o  = mem_grant & (sel == SRC_DATA);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INSTR;
    end else begin
      lock_q     <= mem_req_o & ~mem_gnt_i;
      lock_src_q <= sel;
    end
  end

  miriscv_arb_src_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_src_fifo (
    .clk_i    (clk_i),
    .arstn_i  (arstn_i),
    .push     (mem_grant),
    .push_src (sel),
    .pop      (mem_rvalid_i),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Responses route straight through from the FIFO head with no added latency.
  assign rsp_ok         = mem_rvalid_i & ~fifo_empty;
  assign instr_rvalid_o = rsp_ok & (fifo_head == SRC_INSTR);
  assign data_rvalid_o  = rsp_ok & (fifo_head == SRC_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      err_q <= 1'b0;
    end else if (mem_rvalid_i && fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  assign arb_err_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_miriscv_mem_arbiter.sv
// Scoreboard bench for miriscv_mem_arbiter: directed vectors, response queue checked by a monitor.
`default_nettype none

module tb_miriscv_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        arb_err_o;

  always #5 clk_i = ~clk_i;

  miriscv_mem_arbiter #(.MAX_OUTST(2)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .arb_err_o(arb_err_o)
  );

  typedef struct {
    logic        is_data;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic to_neg();
    @(negedge clk_i);
  endtask

  task automatic to_next();
    @(posedge clk_i);
    #1;
  endtask

  // Drive a memory response and record who must receive it.
  task automatic rsp(input logic is_data, input logic [31:0] d);
    exp_t e;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
    e.is_data    = is_data;
    e.data       = d;
    exp_q.push_back(e);
  endtask

  task automatic no_rsp();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  // Monitor: every routed response must match the queue head.
  always @(negedge clk_i) begin
    if (arstn_i && (instr_rvalid_o || data_rvalid_o)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, data_rvalid_o, instr_rvalid_o}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_instr_rvalid", {31'd0, instr_rvalid_o}, {31'd0, ~e.is_data});
        chk("rsp_data_rvalid",  {31'd0, data_rvalid_o},  {31'd0, e.is_data});
        chk("rsp_rdata", e.is_data ? data_rdata_o : instr_rdata_o, e.data);
      end
    end
  end

  task automatic pulse_reset();
    arstn_i = 1'b0;
    to_next();
    arstn_i = 1'b1;
  endtask

  initial begin
    logic exp_d;
    arstn_i = 1'b0;
    instr_req_i = 0; instr_addr_i = '0;
    data_req_i = 0; data_we_i = 0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;

    // Reset state
    to_neg();
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_gnts", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
    chk("rst_rvalids", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    chk("rst_err", {31'd0, arb_err_o}, 32'd0);
    to_next();
    arstn_i = 1'b1;
    to_next();

    // Single fetch
    instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
    to_neg();
    chk("t1_instr_gnt", {31'd0, instr_gnt_o}, 32'd1);
    chk("t1_data_gnt", {31'd0, data_gnt_o}, 32'd0);
    chk("t1_be", {28'd0, mem_be_o}, 32'hF);
    chk("t1_addr", mem_addr_o, 32'h100);
    chk("t1_wdata_we", {mem_wdata_o[30:0], mem_we_o}, 32'd0);
    to_next();
    instr_req_i = 0; mem_gnt_i = 0;
    rsp(1'b0, 32'h13);
    to_next();
    no_rsp();

    // Both request: data first, then instr; FIFO fills
    instr_req_i = 1; instr_addr_i = 32'h104;
    data_req_i = 1; data_we_i = 0; data_be_i = 4'h3; data_addr_i = 32'h200; data_wdata_i = 32'hDEAD;
    mem_gnt_i = 1;
    to_neg();
    chk("t2_data_gnt", {31'd0, data_gnt_o}, 32'd1);
    chk("t2_instr_gnt", {31'd0, instr_gnt_o}, 32'd0);
    chk("t2_addr", mem_addr_o, 32'h200);
    chk("t2_be", {28'd0, mem_be_o}, 32'h3);
    to_next();
    data_req_i = 0;
    to_neg();
    chk("t2_instr_gnt2", {31'd0, instr_gnt_o}, 32'd1);
    chk("t2_addr2", mem_addr_o, 32'h104);
    to_next();
    instr_req_i = 0;
    data_req_i = 1; data_we_i = 1; data_be_i = 4'hF; data_addr_i = 32'h208; data_wdata_i = 32'hCAFE;
    to_neg();
    chk("t4_full_req", {31'd0, mem_req_o}, 32'd0);
    chk("t4_full_gnt", {31'd0, data_gnt_o}, 32'd0);
    to_next();
    rsp(1'b1, 32'hA);
    to_neg();
    chk("t4_full_pop_req", {31'd0, mem_req_o}, 32'd0);
    to_next();
    rsp(1'b0, 32'hB);
    to_neg();
    chk("t4_reopen_req", {31'd0, mem_req_o}, 32'd1);
    chk("t4_wr_gnt", {31'd0, data_gnt_o}, 32'd1);
    chk("t4_wr_we", {31'd0, mem_we_o}, 32'd1);
    chk("t4_wr_wdata", mem_wdata_o, 32'hCAFE);
    to_next();
    data_req_i = 0; data_we_i = 0;
    rsp(1'b1, 32'hC);
    to_next();
    no_rsp(); mem_gnt_i = 0;

    // Lock: instr stalled, data arrives later and must wait
    instr_req_i = 1; instr_addr_i = 32'h110;
    data_addr_i = 32'h300; data_be_i = 4'h1;
    for (int k = 0; k < 3; k++) begin
      to_neg();
      chk("t5_lock_addr", mem_addr_o, 32'h110);
      chk("t5_lock_gnts", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
      to_next();
      data_req_i = 1;
    end
    mem_gnt_i = 1;
    to_neg();
    chk("t5_instr_gnt", {30'd0, instr_gnt_o, data_gnt_o}, 32'd2);
    to_next();
    instr_req_i = 0;
    to_neg();
    chk("t5_data_gnt", {30'd0, instr_gnt_o, data_gnt_o}, 32'd1);
    to_next();
    data_req_i = 0; mem_gnt_i = 0;
    rsp(1'b0, 32'h21);
    to_next();
    rsp(1'b1, 32'h22);
    to_next();
    no_rsp();

    // Requester withdraws without grant: lock released
    instr_req_i = 1; instr_addr_i = 32'h120;
    to_next();
    instr_req_i = 0; data_req_i = 1; data_addr_i = 32'h304;
    to_neg();
    chk("t5_drop_addr", mem_addr_o, 32'h304);
    to_next();
    data_req_i = 0;
    to_next();

    // rvalid with nothing outstanding
    mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    to_neg();
    chk("t6_orphan_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    to_next();
    no_rsp();
    chk("t6_err_set", {31'd0, arb_err_o}, 32'd1);
    arstn_i = 1'b0;
    #1;
    chk("t6_err_cleared", {31'd0, arb_err_o}, 32'd0);
    to_next();
    arstn_i = 1'b1;

    // Reset mid-transaction, late response afterwards
    instr_req_i = 1; instr_addr_i = 32'h130; mem_gnt_i = 1;
    to_neg();
    chk("t6_mid_gnt", {31'd0, instr_gnt_o}, 32'd1);
    to_next();
    instr_req_i = 0; mem_gnt_i = 0;
    pulse_reset();
    mem_rvalid_i = 1; mem_rdata_i = 32'h77;
    to_neg();
    chk("t6_late_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    to_next();
    no_rsp();
    to_neg();
    chk("t6_late_err", {31'd0, arb_err_o}, 32'd1);
    to_next();
    pulse_reset();

    // Both held, grant every cycle: RR alternates D,I,D,I; fixed priority stays D
    instr_req_i = 1; instr_addr_i = 32'h400;
    data_req_i = 1; data_we_i = 0; data_be_i = 4'hF; data_addr_i = 32'h500;
    mem_gnt_i = 1;
    exp_d = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef MIRISCV_ARB_RR_EN
      logic cur_d;
      cur_d = (k % 2 == 0);
`else
      logic cur_d;
      cur_d = 1'b1;
`endif
      if (k > 0) rsp(exp_d, 32'h300 + k - 1);
      to_neg();
      chk("t3_gnt_seq", {30'd0, instr_gnt_o, data_gnt_o}, cur_d ? 32'd1 : 32'd2);
      chk("t3_addr", mem_addr_o, cur_d ? 32'h500 : 32'h400);
      to_next();
      exp_d = cur_d;
    end
    instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0;
    rsp(exp_d, 32'h303);
    to_next();
    no_rsp();
    to_next();
    to_neg();

    chk("leftover_responses", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
